cluster_scheduler: RTL
======================

Name: cluster_scheduler

Overview:
Parametrised successor to the 4-PE cluster controller. It fetches NUM_PE-wide instruction bundles and issues the longest hazard-free in-order prefix to the PEs. Unissued lanes are refetched in the next bundle, so no pending queue is needed. It tracks per-lane completion and PE-reported control-flow redirects, and halts on an all-zero instruction word. It sits between the instruction memory and the PE array.

Parameters:
NUM_PE, 4, number of PE lanes (1..8); bundle width is NUM_PE*32.
PC_STEP, 1, PC increment per lane (1 = word-addressed IM, 4 = byte-addressed).
CNT_W, 32, width of the issued-instruction counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; honoured only in IDLE or HALTED.
start_pc  input  32  PC loaded on an accepted start.
im_req  output  1  instruction fetch request, held until im_valid.
im_addr  output  NUM_PE*32  per-lane fetch PC; lane i at bits [32i+31:32i].
im_valid  input  1  im_data valid; sampled only while im_req=1.
im_data  input  NUM_PE*32  fetched bundle; lane i at bits [32i+31:32i].
pe_issue_valid  output  NUM_PE  one-cycle issue strobe per lane.
pe_pc  output  NUM_PE*32  PC of the issued instruction per lane.
pe_inst  output  NUM_PE*32  issued instruction per lane.
pe_done  input  NUM_PE  lane finished its issued instruction (pulse).
pe_redirect  input  NUM_PE  qualifies pe_done: lane took a branch or jump.
pe_target  input  NUM_PE*32  redirect target, valid with pe_done&pe_redirect.
busy  output  1  high in FETCH, ISSUE and WAIT.
halted  output  1  high in HALTED.
issued_total  output  CNT_W  count of instructions issued; wraps.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, including im_req, im_addr, pe_*, busy, halted and issued_total. Internal pc, bundle, masks and redirect register cleared. Reset mid-operation abandons the bundle; PEs are not notified.
- All outputs are registered. PC arithmetic is modulo 2^32.

Decode (per lane, combinational on the latched bundle):
- writes_rd for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
- uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- uses_rs2 for 0110011, 0100011, 1100011.
- is_cf for 1100011, 1101111, 1100111.
- rd is bits [11:7], rs1 is [19:15], rs2 is [24:20]. A register field equal to x0 never creates a hazard.

Issue count k:
- k is the smallest j such that any of the following holds:
  - lane j's word is 32'h0;
  - lane j has a RAW or WAW hazard against an earlier lane i<j, i.e. writes_rd_i and rd_i!=0 and (uses_rs1_j and rs1_j==rd_i, or uses_rs2_j and rs2_j==rd_i, or writes_rd_j and rd_j==rd_i);
  - lane j-1 is_cf.
- If no lane meets these conditions, k=NUM_PE.

FSM:
- IDLE: on start, pc<=start_pc and go to FETCH.
- FETCH: im_req=1 and im_addr lane i = pc + i*PC_STEP, held stable. On im_valid, latch im_data and go to ISSUE. im_req falls the following cycle.
- ISSUE (exactly 1 cycle):
  - If k==0, go to HALTED with no strobes.
  - Otherwise, on the next edge drive pe_issue_valid[i]=1 for i<k, with pe_inst/pe_pc set to the bundle word and pc+i*PC_STEP. Strobes last 1 cycle; lanes >=k read 0.
  - Set issued_mask = lanes<k, pc_next = pc + k*PC_STEP, issued_total += k, then go to WAIT.
- WAIT:
  - done_mask |= pe_done & issued_mask. pe_done on unissued lanes is ignored.
  - The redirect register captures the target from the lowest-indexed lane with done&redirect. A lower lane arriving later overrides a higher one.
  - When (done_mask | pe_done&issued_mask) == issued_mask: pc <= captured redirect if present, else pc_next. Clear the masks and redirect register, then go to FETCH the next cycle.
- HALTED: halted=1 and busy=0. start re-enters FETCH with start_pc.
- start outside IDLE/HALTED is ignored.

Latency: im_valid to issue strobe is 2 cycles. Final pe_done to the next im_req is 1 cycle.

Test Plan:
- Independent bundle: start_pc=0; im_data = addi x1..x4,x0,imm → all four strobes in one cycle, pe_pc={3,2,1,0}, issued_total=4, and after the last pe_done the next im_addr lane0=4.
- RAW: lane0 addi x1,x0,1; lane1 add x2,x1,x1; lanes 2-3 independent → only lane0 issues, next fetch lane0 addr=1.
- x0 immunity and WAW: lane0=32'h00000013 (writes x0), lane1 reads x0, lane2 addi x5, lane3 addi x5 → k=3; next fetch at pc+3.
- Branch: lane1 beq → k=2. pe_done=0011, pe_redirect=0010, pe_target lane1=0x20 → next im_addr lane0=0x20. Repeat with a redirect on lane0 arriving after lane1 → lane0 target wins.
- Out-of-order done: issued 1111, pe_done 0100 then 0001, then 1010 together, plus a spurious done while the mask is short → FETCH starts exactly 1 cycle after the final done and never earlier.
- Halt/reset: lane0 word 0 → HALTED, no strobes, halted=1, and a new start restarts the fetch. Driving reset low mid-WAIT → all outputs 0 immediately and IDLE.

Source files
------------

// File: rtl/cluster_scheduler.sv
// cluster_scheduler: fetches NUM_PE-wide instruction bundles and issues the
// longest hazard-free in-order prefix to the PE array. Lanes left unissued
// are fetched again at the head of the next bundle, so nothing is queued.
// The scheduler then waits for every issued lane to finish. The lowest lane
// that reports a redirect supplies the next PC. An all-zero word halts.
//
// Fetch handshake: im_req is raised with im_addr and both are held stable
// until im_valid is seen high while im_req is high. That cycle transfers
// im_data, and im_req drops on the following cycle. im_valid is ignored
// whenever im_req is low.
//
// Lane i of every wide bus sits at bits [32i+31:32i]. state_q is the
// observable FSM state for binding checkers.
module cluster_scheduler #(
  parameter int NUM_PE  = 4,
  parameter int PC_STEP = 1,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          start_pc,
  output logic                 im_req,
  output logic [NUM_PE*32-1:0] im_addr,
  input  logic                 im_valid,
  input  logic [NUM_PE*32-1:0] im_data,
  output logic [NUM_PE-1:0]    pe_issue_valid,
  output logic [NUM_PE*32-1:0] pe_pc,
  output logic [NUM_PE*32-1:0] pe_inst,
  input  logic [NUM_PE-1:0]    pe_done,
  input  logic [NUM_PE-1:0]    pe_redirect,
  input  logic [NUM_PE*32-1:0] pe_target,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     issued_total
);

  localparam int KW = $clog2(NUM_PE + 1);
  localparam int LW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           pc_next_q, pc_next_d;
  logic [NUM_PE*32-1:0]  bundle_q, bundle_d;
  logic [NUM_PE-1:0]     issued_mask_q, issued_mask_d;
  logic [NUM_PE-1:0]     done_mask_q, done_mask_d;
  logic                  redir_valid_q, redir_valid_d;
  logic [LW-1:0]         redir_lane_q, redir_lane_d;
  logic [31:0]           redir_target_q, redir_target_d;

  logic                  im_req_d;
  logic [NUM_PE*32-1:0]  im_addr_d;
  logic [NUM_PE-1:0]     pe_issue_valid_d;
  logic [NUM_PE*32-1:0]  pe_pc_d;
  logic [NUM_PE*32-1:0]  pe_inst_d;
  logic                  busy_d;
  logic                  halted_d;
  logic [CNT_W-1:0]      issued_total_d;

  // Per-lane decode of the latched bundle
  logic [4:0]            rd   [NUM_PE];
  logic [4:0]            rs1  [NUM_PE];
  logic [4:0]            rs2  [NUM_PE];
  logic [NUM_PE-1:0]     wr, u1, u2, cf, cf_prev;
  logic [NUM_PE-1:0]     stop_lane;
  logic [NUM_PE-1:0]     issue_mask;
  logic [KW-1:0]         k;
  logic                  k_found;

  // Completion and redirect tracking
  logic [NUM_PE-1:0]     done_now, redir_now;
  logic                  cand_valid, take_cand, eff_valid, all_done;
  logic [LW-1:0]         cand_lane;
  logic [31:0]           cand_target, eff_target, new_pc;

  function automatic logic op_writes_rd(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                      7'b0010111, 7'b1101111, 7'b1100111};
  endfunction

  function automatic logic op_uses_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1100111};
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic logic op_is_cf(input logic [6:0] op);
    return op inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction

  // PCs of every lane for a bundle starting at base (wraps modulo 2^32)
  function automatic logic [NUM_PE*32-1:0] lane_addrs(input logic [31:0] base);
    logic [NUM_PE*32-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      r[i*32 +: 32] = base + 32'(i) * 32'(PC_STEP);
    end
    return r;
  endfunction

  // Decode register fields and opcode classes for each lane
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      rd[i]  = bundle_q[i*32 + 7  +: 5];
      rs1[i] = bundle_q[i*32 + 15 +: 5];
      rs2[i] = bundle_q[i*32 + 20 +: 5];
      wr[i]  = op_writes_rd(bundle_q[i*32 +: 7]);
      u1[i]  = op_uses_rs1(bundle_q[i*32 +: 7]);
      u2[i]  = op_uses_rs2(bundle_q[i*32 +: 7]);
      cf[i]  = op_is_cf(bundle_q[i*32 +: 7]);
    end
  end

  // A lane after a control-flow lane may not issue in the same bundle
  assign cf_prev = cf << 1;

  // Flag each lane that must not issue: zero word, RAW/WAW on an earlier
  // lane's rd (x0 excluded), or sitting behind a control-flow instruction
  always_comb begin
    stop_lane = '0;
    for (int j = 0; j < NUM_PE; j++) begin
      if (bundle_q[j*32 +: 32] == 32'h0) stop_lane[j] = 1'b1;
      if (cf_prev[j]) stop_lane[j] = 1'b1;
      for (int i = 0; i < NUM_PE; i++) begin
        if (i < j && wr[i] && rd[i] != 5'd0 &&
            ((u1[j] && rs1[j] == rd[i]) ||
             (u2[j] && rs2[j] == rd[i]) ||
             (wr[j] && rd[j] == rd[i]))) begin
          stop_lane[j] = 1'b1;
        end
      end
    end
  end

  // Issue count: index of the first stopped lane, or NUM_PE if none
  always_comb begin
    k       = KW'(NUM_PE);
    k_found = 1'b0;
    for (int j = 0; j < NUM_PE; j++) begin
      if (stop_lane[j] && !k_found) begin
        k       = KW'(j);
        k_found = 1'b1;
      end
    end
  end

  // Thermometer mask of the lanes below k
  always_comb begin
    issue_mask = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      issue_mask[i] = (KW'(i) < k);
    end
  end

  assign done_now  = pe_done & issued_mask_q;
  assign redir_now = done_now & pe_redirect;

  // Lowest lane reporting a redirect in this cycle
  always_comb begin
    cand_valid  = 1'b0;
    cand_lane   = '0;
    cand_target = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (redir_now[i]) begin
        cand_valid  = 1'b1;
        cand_lane   = LW'(i);
        cand_target = pe_target[i*32 +: 32];
      end
    end
  end

  // A lower lane overrides a previously captured higher-lane redirect
  assign take_cand  = cand_valid && (!redir_valid_q || cand_lane < redir_lane_q);
  assign eff_valid  = take_cand || redir_valid_q;
  assign eff_target = take_cand ? cand_target : redir_target_q;
  assign all_done   = ((done_mask_q | done_now) == issued_mask_q);
  assign new_pc     = eff_valid ? eff_target : pc_next_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pc_next_d        = pc_next_q;
    bundle_d         = bundle_q;
    issued_mask_d    = issued_mask_q;
    done_mask_d      = done_mask_q;
    redir_valid_d    = redir_valid_q;
    redir_lane_d     = redir_lane_q;
    redir_target_d   = redir_target_q;
    im_req_d         = im_req;
    im_addr_d        = im_addr;
    pe_issue_valid_d = '0;
    pe_pc_d          = '0;
    pe_inst_d        = '0;
    issued_total_d   = issued_total;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d      = start_pc;
          im_req_d  = 1'b1;
          im_addr_d = lane_addrs(start_pc);
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        im_req_d = 1'b1;
        if (im_req && im_valid) begin
          bundle_d = im_data;
          im_req_d = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (k == '0) begin
          state_d = S_HALTED;
        end else begin
          for (int i = 0; i < NUM_PE; i++) begin
            if (issue_mask[i]) begin
              pe_issue_valid_d[i]   = 1'b1;
              pe_pc_d[i*32 +: 32]   = pc_q + 32'(i) * 32'(PC_STEP);
              pe_inst_d[i*32 +: 32] = bundle_q[i*32 +: 32];
            end
          end
          issued_mask_d  = issue_mask;
          pc_next_d      = pc_q + 32'(k) * 32'(PC_STEP);
          issued_total_d = issued_total + CNT_W'(k);
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        done_mask_d = done_mask_q | done_now;
        if (take_cand) begin
          redir_valid_d  = 1'b1;
          redir_lane_d   = cand_lane;
          redir_target_d = cand_target;
        end
        if (all_done) begin
          pc_d           = new_pc;
          issued_mask_d  = '0;
          done_mask_d    = '0;
          redir_valid_d  = 1'b0;
          redir_lane_d   = '0;
          redir_target_d = '0;
          im_req_d       = 1'b1;
          im_addr_d      = lane_addrs(new_pc);
          state_d        = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT);
    halted_d = (state_d == S_HALTED);
  end

  // State and output registers; reset abandons any bundle in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      pc_next_q      <= '0;
      bundle_q       <= '0;
      issued_mask_q  <= '0;
      done_mask_q    <= '0;
      redir_valid_q  <= 1'b0;
      redir_lane_q   <= '0;
      redir_target_q <= '0;
      im_req         <= 1'b0;
      im_addr        <= '0;
      pe_issue_valid <= '0;
      pe_pc          <= '0;
      pe_inst        <= '0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      issued_total   <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_next_q      <= pc_next_d;
      bundle_q       <= bundle_d;
      issued_mask_q  <= issued_mask_d;
      done_mask_q    <= done_mask_d;
      redir_valid_q  <= redir_valid_d;
      redir_lane_q   <= redir_lane_d;
      redir_target_q <= redir_target_d;
      im_req         <= im_req_d;
      im_addr        <= im_addr_d;
      pe_issue_valid <= pe_issue_valid_d;
      pe_pc          <= pe_pc_d;
      pe_inst        <= pe_inst_d;
      busy           <= busy_d;
      halted         <= halted_d;
      issued_total   <= issued_total_d;
    end
  end

endmodule
